// File: rtl/rand_stream_client_pkg.sv
// Shared definitions for the random-stream client: FSM states and word width.
package rand_stream_client_pkg;

    localparam int unsigned RAND_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/rand_stream_client_if.sv
// Source request/response and downstream valid/ready stream of the random-stream client.
interface rand_stream_client_if;
    import rand_stream_client_pkg::*;

    logic              REQ_WRITE;
    logic              REQ_WRITE_VALID;
    logic [RAND_W-1:0] RESP_READ;
    logic              RESP_READ_VALID;
    logic              SRC_DONE;
    logic [RAND_W-1:0] OUT_DATA;
    logic              OUT_VALID;
    logic              OUT_READY;

    modport master (
        output REQ_WRITE, REQ_WRITE_VALID, OUT_DATA, OUT_VALID,
        input  RESP_READ, RESP_READ_VALID, SRC_DONE, OUT_READY
    );

    modport slave (
        input  REQ_WRITE, REQ_WRITE_VALID, OUT_DATA, OUT_VALID,
        output RESP_READ, RESP_READ_VALID, SRC_DONE, OUT_READY
    );

endinterface

// File: rtl/rand_stream_fifo.sv
// Circular DEPTH-entry synchronous FIFO; push and pop may coincide, including when full.
module rand_stream_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         wr_en, rd_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (wr_en) wr_d = wr_q + 1'b1;
        if (rd_en) rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/rand_stream_client.sv
// Burst fetcher: pulls COUNT masked words from a random source into a FIFO and streams them out.
module rand_stream_client
    import rand_stream_client_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [CNT_W-1:0]     COUNT,
    input  logic [RAND_W-1:0]    MASK,
    rand_stream_client_if.master bus,
    output logic                 BUSY,
    output logic                 FINISHED,
    output logic                 ERR
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [RAND_W-1:0]  mask_q, mask_d;
    logic               busy_q, busy_d;
    logic               fin_q, fin_d;
    logic               err_q, err_d;

    logic [RAND_W-1:0]  fifo_head;
    logic               fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_cnt;
    logic               pop, issue, push;

    assign pop   = !fifo_empty && bus.OUT_READY;
    assign issue = (state_q == FETCH) && bus.SRC_DONE && (rem_q != '0) && (!fifo_full || pop);
    assign push  = issue && bus.RESP_READ_VALID;

    rand_stream_fifo #(
        .DEPTH (DEPTH),
        .W     (RAND_W)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .push_i      (push),
        .push_data_i (bus.RESP_READ & mask_q),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mask_d  = mask_q;
        fin_d   = 1'b0;
        err_d   = err_q | (issue & ~bus.RESP_READ_VALID);
        case (state_q)
            IDLE: begin
                if (START) begin
                    rem_d   = COUNT;
                    mask_d  = MASK;
                    state_d = (COUNT == '0) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (push) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the last buffered word is popped, not a cycle later.
                if (fifo_empty || (fifo_cnt == CW'(1) && pop)) begin
                    state_d = IDLE;
                    fin_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            rem_q   <= '0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
        end
    end

    assign bus.REQ_WRITE       = issue;
    assign bus.REQ_WRITE_VALID = issue;
    assign bus.OUT_DATA        = fifo_head;
    assign bus.OUT_VALID       = !fifo_empty;
    assign BUSY                = busy_q;
    assign FINISHED            = fin_q;
    assign ERR                 = err_q;

endmodule

// File: tb/tb_rand_stream_client.sv
// Directed/randomized bench for rand_stream_client with a word-table source and an expected-word queue.
module tb_rand_stream_client;
    import rand_stream_client_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             START;
    logic [CNT_W-1:0] COUNT;
    logic [31:0]      MASK;
    logic             BUSY, FINISHED, ERR;

    rand_stream_client_if bus();

    rand_stream_client #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .COUNT    (COUNT),
        .MASK     (MASK),
        .bus      (bus),
        .BUSY     (BUSY),
        .FINISHED (FINISHED),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    // Source: a table of words, advanced by one entry after every request cycle.
    logic [31:0]  src_mem [256];
    logic [7:0]   src_idx;
    int unsigned  req_total, pop_total, fin_total, bad_at;
    int           cyc;
    bit           req_seen, rnd_ready;
    logic [31:0]  cur_mask;
    logic [31:0]  exp_q [$];
    int           checks, errors;
    int           s, fc;
    int unsigned  r0, p0, f0;
    logic [31:0]  m;

    assign bus.RESP_READ       = src_mem[src_idx];
    assign bus.RESP_READ_VALID = (req_total != bad_at);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the current cycle's outputs and update the reference model.
    task automatic to_neg();
        logic [31:0] e;
        @(negedge CLK);
        cyc++;
        if (RESET) begin
            exp_q.delete();
        end else begin
            if (bus.OUT_VALID && bus.OUT_READY) begin
                pop_total++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                chk("pop_data", bus.OUT_DATA, e);
            end
            if (bus.REQ_WRITE && bus.RESP_READ_VALID) exp_q.push_back(bus.RESP_READ & cur_mask);
        end
        if (bus.REQ_WRITE || bus.REQ_WRITE_VALID) chk("req_valid_eq", bus.REQ_WRITE_VALID, bus.REQ_WRITE);
        req_seen = bus.REQ_WRITE;
        if (FINISHED) fin_total++;
    endtask

    task automatic to_next();
        @(posedge CLK);
        #1;
        if (req_seen) begin
            req_total++;
            src_idx++;
        end
        req_seen = 1'b0;
        if (rnd_ready) bus.OUT_READY = 1'($urandom_range(0, 1));
    endtask

    task automatic cycle();
        to_neg();
        to_next();
    endtask

    task automatic start_burst(input logic [CNT_W-1:0] n, input logic [31:0] msk, output int sc);
        START    = 1'b1;
        COUNT    = n;
        MASK     = msk;
        cur_mask = msk;
        to_neg();
        sc = cyc;
        to_next();
        START = 1'b0;
        COUNT = CNT_W'($urandom);
        MASK  = $urandom;
    endtask

    task automatic run_to_finish(input int budget, output int fcyc);
        fcyc = -1;
        for (int i = 0; i < budget && fcyc < 0; i++) begin
            to_neg();
            if (FINISHED) fcyc = cyc;
            to_next();
        end
        chk("finish_seen", 32'(fcyc >= 0), 32'd1);
        to_neg();
        chk("finish_one_cycle", 32'(FINISHED), 32'd0);
        chk("busy_after", 32'(BUSY), 32'd0);
        to_next();
    endtask

    initial begin
        checks = 0; errors = 0;
        req_total = 0; pop_total = 0; fin_total = 0; cyc = 0;
        bad_at = '1; src_idx = '0; req_seen = 1'b0; rnd_ready = 1'b0;
        cur_mask = '0;
        for (int i = 0; i < 256; i++) src_mem[i] = $urandom;
        RESET = 1'b1; START = 1'b0; COUNT = '0; MASK = '0;
        bus.SRC_DONE = 1'b1; bus.OUT_READY = 1'b1;

        // Reset state
        cycle();
        to_neg();
        chk("rst_req", 32'(bus.REQ_WRITE), 0);
        chk("rst_req_valid", 32'(bus.REQ_WRITE_VALID), 0);
        chk("rst_out_valid", 32'(bus.OUT_VALID), 0);
        chk("rst_out_data", bus.OUT_DATA, 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_finished", 32'(FINISHED), 0);
        chk("rst_err", 32'(ERR), 0);
        to_next();
        RESET = 1'b0;
        cycle();

        // 1: five full-mask words, no backpressure
        r0 = req_total; p0 = pop_total; f0 = fin_total;
        start_burst(5, 32'hFFFF_FFFF, s);
        to_neg();
        chk("t1_busy", 32'(BUSY), 1);
        to_next();
        run_to_finish(50, fc);
        chk("t1_fin_cycle", fc, s + 7);
        chk("t1_reqs", req_total - r0, 5);
        chk("t1_pops", pop_total - p0, 5);
        chk("t1_fin_pulses", fin_total - f0, 1);
        chk("t1_q_empty", exp_q.size(), 0);

        // 2: byte mask, downstream stalled long enough to fill the FIFO
        bus.OUT_READY = 1'b0;
        r0 = req_total; p0 = pop_total; f0 = fin_total;
        start_burst(10, 32'h0000_00FF, s);
        repeat (20) cycle();
        to_neg();
        chk("t2_stall_reqs", req_total - r0, DEPTH);
        chk("t2_full_valid", 32'(bus.OUT_VALID), 1);
        chk("t2_head_masked", bus.OUT_DATA & ~32'hFF, 0);
        to_next();
        bus.OUT_READY = 1'b1;
        run_to_finish(100, fc);
        chk("t2_reqs", req_total - r0, 10);
        chk("t2_pops", pop_total - p0, 10);
        chk("t2_fin_pulses", fin_total - f0, 1);
        chk("t2_q_empty", exp_q.size(), 0);

        // 3: source not ready for 7 cycles, then random downstream readiness
        bus.SRC_DONE = 1'b0;
        r0 = req_total; p0 = pop_total; f0 = fin_total;
        m = $urandom;
        start_burst(6, m, s);
        for (int i = 0; i < 7; i++) begin
            to_neg();
            chk("t3_no_req_hold", 32'(bus.REQ_WRITE), 0);
            to_next();
        end
        bus.SRC_DONE = 1'b1;
        rnd_ready = 1'b1;
        run_to_finish(200, fc);
        rnd_ready = 1'b0;
        bus.OUT_READY = 1'b1;
        chk("t3_reqs", req_total - r0, 6);
        chk("t3_pops", pop_total - p0, 6);
        chk("t3_fin_pulses", fin_total - f0, 1);
        chk("t3_q_empty", exp_q.size(), 0);

        // 4: second request of a 3-word burst gets no valid response
        chk("t4_err_before", 32'(ERR), 0);
        r0 = req_total; p0 = pop_total;
        bad_at = req_total + 1;
        m = $urandom;
        start_burst(3, m, s);
        run_to_finish(50, fc);
        bad_at = '1;
        chk("t4_err", 32'(ERR), 1);
        chk("t4_reqs", req_total - r0, 4);
        chk("t4_pops", pop_total - p0, 3);
        chk("t4_q_empty", exp_q.size(), 0);

        // 5: empty burst, then a START pulse during FETCH that must be ignored
        r0 = req_total;
        start_burst(0, $urandom, s);
        run_to_finish(20, fc);
        chk("t5_zero_fin_cycle", fc, s + 2);
        chk("t5_zero_reqs", req_total - r0, 0);
        chk("t5_err_sticky", 32'(ERR), 1);
        r0 = req_total; p0 = pop_total; f0 = fin_total;
        m = $urandom | 32'h1;
        start_burst(4, m, s);
        START = 1'b1; COUNT = 9; MASK = '0;
        cycle();
        START = 1'b0;
        run_to_finish(50, fc);
        chk("t5_ign_reqs", req_total - r0, 4);
        chk("t5_ign_pops", pop_total - p0, 4);
        chk("t5_ign_fin", fin_total - f0, 1);

        // 6: reset with two words buffered, then a clean burst
        bus.OUT_READY = 1'b0;
        r0 = req_total;
        start_burst(8, 32'hFFFF_FFFF, s);
        cycle();
        cycle();
        bus.SRC_DONE = 1'b0;
        to_neg();
        chk("t6_buffered_reqs", req_total - r0, 2);
        chk("t6_valid_before", 32'(bus.OUT_VALID), 1);
        to_next();
        f0 = fin_total;
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        to_neg();
        chk("t6_out_valid", 32'(bus.OUT_VALID), 0);
        chk("t6_out_data", bus.OUT_DATA, 0);
        chk("t6_busy", 32'(BUSY), 0);
        chk("t6_err", 32'(ERR), 0);
        chk("t6_finished", 32'(FINISHED), 0);
        to_next();
        repeat (5) cycle();
        chk("t6_no_fin", fin_total - f0, 0);
        bus.SRC_DONE = 1'b1;
        bus.OUT_READY = 1'b1;
        r0 = req_total; p0 = pop_total; f0 = fin_total;
        m = $urandom;
        start_burst(5, m, s);
        run_to_finish(50, fc);
        chk("t6_fin_cycle", fc, s + 7);
        chk("t6_reqs", req_total - r0, 5);
        chk("t6_pops", pop_total - p0, 5);
        chk("t6_fin_pulses", fin_total - f0, 1);
        chk("t6_err_clean", 32'(ERR), 0);
        chk("t6_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rand_stream_client.md
# rand_stream_client

Consumer end of the 32-bit random-number request/response interface: the initiator that drives REQ_WRITE/REQ_WRITE_VALID into a random source (Rand32 server) and captures RESP_READ/RESP_READ_VALID. On a START command it fetches a programmed number of words, applies a latched bit mask, buffers them in a small FIFO, and delivers them downstream on a valid/ready stream. It sits between the random source and any test-traffic or stimulus generator.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CNT_W, 16, width of burst-count input and internal remaining counter.
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset, synchronous, active-high.
- START  in  1  command pulse; accepted only in IDLE.
- COUNT  in  CNT_W  words to fetch; sampled with accepted START.
- MASK  in  32  AND-mask applied to each word; sampled with accepted START.
- REQ_WRITE  out  1  request strobe to source (advance generator).
- REQ_WRITE_VALID  out  1  request valid; driven identical to REQ_WRITE.
- RESP_READ  in  32  current random word from source.
- RESP_READ_VALID  in  1  source response valid (same cycle as request).
- SRC_DONE  in  1  source ready; requests issue only while high.
- OUT_DATA  out  32  FIFO head word.
- OUT_VALID  out  1  FIFO non-empty.
- OUT_READY  in  1  downstream accepts head word.
- BUSY  out  1  high outside IDLE.
- FINISHED  out  1  one-cycle pulse when burst fully delivered.
- ERR  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: START=1 → latch COUNT into remaining, MASK into mask_q; go FETCH (COUNT=0 → go DRAIN directly). START ignored in FETCH/DRAIN.
- FETCH: issue = SRC_DONE && remaining≠0 && (FIFO not full || pop this cycle). REQ_WRITE=REQ_WRITE_VALID=issue.
- On issue with RESP_READ_VALID=1: push RESP_READ & mask_q; remaining−1. Word pushed is RESP_READ of the issue cycle (source advances afterward).
- On issue with RESP_READ_VALID=0: no push, no decrement, ERR←1 (sticky until RESET).
- FETCH → DRAIN when remaining reaches 0 (transition in the cycle of last push).
- DRAIN: no requests; when FIFO becomes empty (after final pop) → IDLE, FINISHED=1 that cycle of transition (registered, visible the next cycle for exactly one cycle).
- FIFO: circular, DEPTH entries, rd/wr pointers log2(DEPTH)+1 bits for full/empty; simultaneous push+pop when full allowed (occupancy unchanged).
- Pop = OUT_VALID && OUT_READY. OUT_DATA valid only when OUT_VALID.
- remaining decrement never wraps; guarded by ≠0.
- Reset mid-burst: all state cleared, FIFO emptied, burst abandoned, no FINISHED pulse.

## Timing
- Reset values: REQ_WRITE=0, REQ_WRITE_VALID=0, OUT_VALID=0, OUT_DATA=0, BUSY=0, FINISHED=0, ERR=0; state IDLE, pointers 0, remaining 0, mask_q 0.
- REQ_WRITE combinational from registered state, FIFO status, SRC_DONE and OUT_READY; no path from RESP_READ.
- START accepted at edge N → first request possible in cycle N+1.
- Push at edge → OUT_VALID high next cycle (1-cycle fill latency).
- Sustained throughput 1 word/cycle with OUT_READY=1 and SRC_DONE=1.
- Burst of K words, no backpressure: FINISHED visible K+2 cycles after START-accept cycle.
- BUSY registered, high from cycle after START accept through DRAIN exit.

## Structure
- Shared package: state enum (IDLE/FETCH/DRAIN), RAND_W=32 constant.
- One sub-module: rand_stream_fifo (DEPTH×32 synchronous FIFO with push/pop/full/empty, simultaneous push+pop); FSM, counter, mask and request logic in top.

## Test plan
- START COUNT=5 MASK=0xFFFFFFFF, source seed 0, OUT_READY=1 → exactly 5 requests, OUT_DATA equals first 5 source words in order, FINISHED one pulse, BUSY low after.
- COUNT=10 MASK=0x000000FF, OUT_READY=0 for 20 cycles then 1 → exactly 4 requests while stalled (FIFO full, no overflow), all 10 words ≤0xFF, order preserved.
- SRC_DONE held 0 for 7 cycles after START → no REQ_WRITE during hold, burst completes afterwards with correct words.
- RESP_READ_VALID forced 0 on 2nd request, COUNT=3 → ERR=1 sticky, still exactly 3 words pushed, 4 request cycles total.
- COUNT=0 → no requests, FINISHED pulses 2 cycles after START; START during FETCH ignored (count unchanged).
- RESET asserted mid-burst with 2 words buffered → next cycle OUT_VALID=0, BUSY=0, ERR=0, no FINISHED; new START runs clean burst.
